// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants and helpers, used by the sync
// generator and the pixel renderer.
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  // Inclusive range test on a raw counter value.
  function automatic logic in_window(input logic [CNT_W-1:0] v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) <= hi);
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-N enabled counter; exposes its next value so the parent can
// register decoded outputs in lock-step with the count.
module mod_counter
  import vga_timing_pkg::*;
#(
  parameter int WIDTH   = CNT_W,
  parameter int MODULUS = DEF_H_TOTAL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_next,
  output logic             tc
);

  assign tc = (count == WIDTH'(MODULUS - 1));

  always_comb begin
    count_next = count;
    if (en) begin
      count_next = tc ? '0 : count + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: horizontal/vertical counters plus registered
// sync, blanking and frame-start outputs aligned with the counters.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_en,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             frame_start
);

  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = H_VISIBLE + H_FRONT + H_SYNC - 1;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = V_VISIBLE + V_FRONT + V_SYNC - 1;

  logic [CNT_W-1:0] h_count, h_next, v_count, v_next;
  logic             h_tc, v_tc;

  // pix_en is a one-clk strobe with no back-pressure: every edge it is high
  // consumes exactly one pixel, every edge it is low leaves all state alone.
  mod_counter #(.WIDTH(CNT_W), .MODULUS(H_TOTAL)) u_h_cnt (
    .clk        (clk),
    .reset      (reset),
    .en         (pix_en),
    .count      (h_count),
    .count_next (h_next),
    .tc         (h_tc)
  );

  mod_counter #(.WIDTH(CNT_W), .MODULUS(V_TOTAL)) u_v_cnt (
    .clk        (clk),
    .reset      (reset),
    .en         (pix_en & h_tc),
    .count      (v_count),
    .count_next (v_next),
    .tc         (v_tc)
  );

  assign pixel_x = h_count;
  assign pixel_y = v_count;

  // Decode from next-state counts so the flops line up with pixel_x/pixel_y.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      video_on    <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      hsync       <= in_window(h_next, HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
      vsync       <= in_window(v_next, VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;
      video_on    <= (int'(h_next) < H_VISIBLE) && (int'(v_next) < V_VISIBLE);
      frame_start <= pix_en & h_tc & v_tc;
    end
  end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 The block SHALL have parameter H_VISIBLE, default 640, active pixels per line.
REQ-002 The block SHALL have parameter H_FRONT, default 16, horizontal front porch in pixels.
REQ-003 The block SHALL have parameter H_SYNC, default 96, hsync pulse width in pixels.
REQ-004 The block SHALL have parameter H_BACK, default 48, horizontal back porch in pixels.
REQ-005 The block SHALL have parameter V_VISIBLE, default 480, active lines per frame.
REQ-006 The block SHALL have parameter V_FRONT, default 10, vertical front porch in lines.
REQ-007 The block SHALL have parameter V_SYNC, default 2, vsync pulse width in lines.
REQ-008 The block SHALL have parameter V_BACK, default 33, vertical back porch in lines.
REQ-009 The block SHALL have parameter SYNC_POL, default 0, asserted sync level (0 = active-low).
REQ-010 The block SHALL have port clk, input, 1 bit, system clock.
REQ-011 The block SHALL have port reset, input, 1 bit, asynchronous, active-high reset.
REQ-012 The block SHALL have port pix_en, input, 1 bit, pixel-rate strobe from the clock divider, high for one clk per pixel.
REQ-013 The block SHALL have port hsync, output, 1 bit, horizontal sync.
REQ-014 The block SHALL have port vsync, output, 1 bit, vertical sync.
REQ-015 The block SHALL have port video_on, output, 1 bit, high while the current pixel is in the visible area.
REQ-016 The block SHALL have port pixel_x, output, 10 bits, current horizontal count.
REQ-017 The block SHALL have port pixel_y, output, 10 bits, current vertical count.
REQ-018 The block SHALL have port frame_start, output, 1 bit, one-clk pulse at each frame wrap.

Function
REQ-019 H_TOTAL SHALL equal H_VISIBLE+H_FRONT+H_SYNC+H_BACK (default 800), and V_TOTAL SHALL equal V_VISIBLE+V_FRONT+V_SYNC+V_BACK (default 525).
REQ-020 The horizontal counter SHALL increment on each clk edge with pix_en=1, and SHALL wrap from H_TOTAL-1 to 0.
REQ-021 The vertical counter SHALL increment only on the edge where the horizontal counter wraps, and SHALL wrap from V_TOTAL-1 to 0.
REQ-022 Both counters SHALL hold their value on every edge with pix_en=0.
REQ-023 pix_en held high continuously SHALL advance the counters every clk, with no other behavioural change.
REQ-024 pixel_x and pixel_y SHALL be the counter registers directly, with no added latency.
REQ-025 hsync SHALL equal SYNC_POL when pixel_x is in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] (default 656..751), and ~SYNC_POL otherwise.
REQ-026 vsync SHALL equal SYNC_POL when pixel_y is in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] (default 490..491), and ~SYNC_POL otherwise.
REQ-027 video_on SHALL be 1 exactly when pixel_x<H_VISIBLE and pixel_y<V_VISIBLE.
REQ-028 hsync, vsync and video_on SHALL be registered from next-state counter values, so they always match pixel_x/pixel_y in the same cycle and are glitch-free.
REQ-029 frame_start SHALL be registered and high for exactly the one clk cycle after the edge at which the counters wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0).
REQ-030 frame_start SHALL NOT assert on reset entry or on reset exit.

Reset
REQ-031 On reset=1, the block SHALL immediately set pixel_x=0, pixel_y=0, hsync=~SYNC_POL, vsync=~SYNC_POL, video_on=1 and frame_start=0, regardless of clk.
REQ-032 A reset asserted mid-frame SHALL abandon the frame, and counting SHALL resume from (0,0) on the first pix_en after release.

Structure
REQ-033 The default 640x480@60 timing constants and the derived H_TOTAL/V_TOTAL SHALL live in the shared package vga_timing_pkg, for reuse by the pixel renderer.
REQ-034 The block SHALL instantiate sub-module mod_counter twice: horizontal with enable=pix_en, and vertical with enable=pix_en AND horizontal terminal count.

Verification
REQ-035 Reset, then pix_en every 4th clk -> hsync falls after the 656th pix_en, rises after the 752nd, and pixel_x goes 799->0 with pixel_y 0->1 on the 800th.
REQ-036 Run 420000 pix_en pulses -> exactly one frame_start pulse, one clk wide, with counters at (0,0); vsync is low for 1600 pix_en spanning lines 490-491.
REQ-037 At pixel_x=639 then 640, and pixel_y=479 then 480 -> video_on goes 1->0 on the same cycle as the counter change.
REQ-038 pix_en=0 for 100 clk at (123,45) -> all outputs hold; pix_en high continuously -> pixel_x advances by 1 every clk.
REQ-039 Assert reset asynchronously at (300,200) -> outputs reach their REQ-031 values before the next clk edge, and there is no frame_start pulse.
REQ-040 Set SYNC_POL=1 and run one line -> hsync is high only for pixel_x 656..751.
